// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction fetch stage. Owns the fetch PC, issues word
//               requests over a req/gnt/rvalid handshake and buffers returned
//               words with their PCs. Optional macro FETCH_BYPASS_EN forwards
//               a response straight to decode when the buffer is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      buf_word_q [DEPTH];
    logic [31:0]      buf_word_d [DEPTH];
    logic [31:0]      buf_pc_q   [DEPTH];
    logic [31:0]      buf_pc_d   [DEPTH];
    logic [31:0]      tag_q      [DEPTH];
    logic [31:0]      tag_d      [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic        credit_ok, grant, rsp, drop, store, bypass, push, pop, head_valid;
    logic [31:0] rsp_tag;
    logic        unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];
    assign imem_addr      = fetch_pc_q;

    always_comb begin
        credit_ok  = ({1'b0, count_q} + {1'b0, outstanding_q}) < SUM_W'(DEPTH);
        imem_req   = rstn && !redirect && credit_ok;
        grant      = imem_req && imem_gnt;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp        = imem_rvalid && (outstanding_q != '0);
        drop       = rsp && (drop_cnt_q != '0);
        store      = rsp && !drop && !redirect;
        rsp_tag    = tag_q[tag_rd_q];
        head_valid = (count_q != '0);
`ifdef FETCH_BYPASS_EN
        bypass      = store && !head_valid && instr_ready;
        instr_valid = head_valid || bypass;
        instr       = bypass ? imem_rdata : buf_word_q[rd_ptr_q];
        instr_pc    = bypass ? rsp_tag    : buf_pc_q[rd_ptr_q];
`else
        bypass      = 1'b0;
        instr_valid = head_valid;
        instr       = buf_word_q[rd_ptr_q];
        instr_pc    = buf_pc_q[rd_ptr_q];
`endif
        push = store && !bypass;
        pop  = head_valid && instr_ready && !redirect;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rsp);
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        tag_wr_d      = grant ? tag_wr_q + PTR_W'(1) : tag_wr_q;
        tag_rd_d      = rsp   ? tag_rd_q + PTR_W'(1) : tag_rd_q;
        buf_word_d    = buf_word_q;
        buf_pc_d      = buf_pc_q;
        tag_d         = tag_q;

        if (grant) begin
            fetch_pc_d      = fetch_pc_q + 32'd4;
            tag_d[tag_wr_q] = fetch_pc_q;
        end
        if (drop) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
        if (push) begin
            buf_word_d[wr_ptr_q] = imem_rdata;
            buf_pc_d[wr_ptr_q]   = rsp_tag;
        end
        // Tag FIFO keeps running across a redirect: stale responses still pop it.
        // Every response this cycle (kept or dropped) retires one in-flight
        // fetch, so the remaining stale count is simply outstanding - rsp.
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            drop_cnt_d = outstanding_q - CNT_W'(rsp);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q    <= RESET_PC;
            buf_word_q    <= '{default: '0};
            buf_pc_q      <= '{default: '0};
            tag_q         <= '{default: '0};
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            buf_word_q    <= buf_word_d;
            buf_pc_q      <= buf_pc_d;
            tag_q         <= tag_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(imem_rvalid && (outstanding_q == '0)))
                else $error("fetch_unit: response with no outstanding fetch");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Directed testbench for fetch_unit (DEPTH=2): reset, streaming, backpressure,
// redirect with stale responses, coincident redirect and PC wrap-around.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'h00A0_0893;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n;
    int first_valid_cyc;

    logic [31:0] mem_q[$];
    logic [31:0] acc_pc[$];
    logic [31:0] acc_instr[$];
    logic [31:0] grant_addr[$];

    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_instr, obs_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] pc_at(input int i);
        if (i < acc_pc.size()) return acc_pc[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] instr_at(input int i);
        if (i < acc_instr.size()) return acc_instr[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] gaddr_at(input int i);
        if (i < grant_addr.size()) return grant_addr[i];
        return 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: drive inputs, sample outputs, then advance the memory model.
    task automatic cycle(input logic gnt, input logic ready, input logic redir,
                         input logic [31:0] rpc, input logic rsp_en);
        imem_gnt    = gnt;
        instr_ready = ready;
        redirect    = redir;
        redirect_pc = rpc;
        if (rsp_en && mem_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0] ^ K;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        cyc_n++;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = instr_valid;
        obs_instr = instr;
        obs_pc    = instr_pc;
        if (obs_valid && ready) begin
            acc_pc.push_back(obs_pc);
            acc_instr.push_back(obs_instr);
        end
        if (obs_valid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
        if (obs_req && gnt) grant_addr.push_back(obs_addr);
        @(posedge clk);
        if (imem_rvalid) void'(mem_q.pop_front());
        if (obs_req && gnt) mem_q.push_back(obs_addr);
        #1;
    endtask

    task automatic reset_assert();
        rstn        = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        mem_q.delete();
        acc_pc.delete();
        acc_instr.delete();
        grant_addr.delete();
        cyc_n           = 0;
        first_valid_cyc = -1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_acc();
        acc_pc.delete();
        acc_instr.delete();
    endtask

    initial begin
        #2;
        // Reset values
        reset_assert();
        check("rst_req",   {31'b0, imem_req},    32'h0);
        check("rst_addr",  imem_addr,            32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr", instr,                32'h0);
        check("rst_pc",    instr_pc,             32'h0);
        rstn = 1'b1;

        // Streaming with 1-cycle responses
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t1_first_req",  {31'b0, obs_req}, 32'h1);
        check("t1_first_addr", obs_addr,         32'h0);
        repeat (9) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t1_pc0",    pc_at(0),    32'h0);
        check("t1_instr0", instr_at(0), 32'h00A0_0893);
        check("t1_pc1",    pc_at(1),    32'h4);
        check("t1_pc2",    pc_at(2),    32'h8);
        check("t1_instr2", instr_at(2), 32'h8 ^ K);
`ifdef FETCH_BYPASS_EN
        check("t1_latency", 32'(first_valid_cyc), 32'd2);
`else
        check("t1_latency", 32'(first_valid_cyc), 32'd3);
`endif

        // Backpressure: two grants then stall, drain restarts fetch at 0x8
        reset_assert();
        rstn = 1'b1;
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t2_ngrants", 32'(grant_addr.size()), 32'd2);
        check("t2_gaddr0",  gaddr_at(0),            32'h0);
        check("t2_gaddr1",  gaddr_at(1),            32'h4);
        check("t2_stall_req", {31'b0, obs_req},     32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t2_drain0_valid", {31'b0, obs_valid}, 32'h1);
        check("t2_drain0_pc",    obs_pc,             32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t2_drain1_pc",  obs_pc,           32'h4);
        check("t2_rearm_req",  {31'b0, obs_req}, 32'h1);
        check("t2_rearm_addr", obs_addr,         32'h8);

        // Redirect with two fetches in flight
        reset_assert();
        rstn = 1'b1;
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
        check("t3_redir_req", {31'b0, obs_req}, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t3_new_addr", obs_addr, 32'h100);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t3_gaddr2",     gaddr_at(2),  32'h100);
        check("t3_first_pc",   pc_at(0),     32'h100);
        check("t3_first_word", instr_at(0),  32'h100 ^ K);

        // Redirect coincident with a response and a pop, target near wrap
        reset_assert();
        rstn = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        check("t4_pop_valid", {31'b0, obs_valid}, 32'h1);
        check("t4_pop_pc",    obs_pc,             32'h0);
        clear_acc();
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t4_empty",    {31'b0, obs_valid}, 32'h0);
        check("t4_req",      {31'b0, obs_req},   32'h1);
        check("t4_addr",     obs_addr,           32'hFFFF_FFF8);
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t4_wrap_pc0",   pc_at(0),    32'hFFFF_FFF8);
        check("t4_wrap_word0", instr_at(0), 32'hFFFF_FFF8 ^ K);
        check("t4_wrap_pc1",   pc_at(1),    32'hFFFF_FFFC);
        check("t4_wrap_pc2",   pc_at(2),    32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core: owns the fetch PC, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned words with their PCs. It sits directly upstream of decode, whose `instr[31:7]` slice feeds the immediate extender. A redirect input from execute (branch/jump target) flushes buffered and in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: instruction buffer entries. Power of two, ≥2. Also the limit on in-flight plus buffered fetches.
- `clk`  in  1  single clock, rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word-aligned fetch address; equals current fetch PC.
- `imem_gnt`  in  1  request accepted this cycle; only meaningful while `imem_req`=1.
- `imem_rvalid`  in  1  response valid. Responses are in order, at least 1 cycle after grant.
- `imem_rdata`  in  32  response instruction word.
- `redirect`  in  1  one-cycle pulse: flush and restart at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address. Bits [1:0] are ignored and forced to 0.
- `instr_valid`  out  1  buffer head holds a valid instruction.
- `instr`  out  32  instruction word at the buffer head.
- `instr_pc`  out  32  PC of `instr`.
- `instr_ready`  in  1  decode accepts the head when `instr_valid`=1.

## Operation
- **State**
  - `fetch_pc` (32 bits).
  - Circular buffer of DEPTH {word, pc} entries, with rd/wr pointers and an occupancy count (0..DEPTH).
  - `outstanding` count: granted fetches without a response yet (0..DEPTH).
  - `drop_cnt`: responses still to be discarded after a redirect (0..DEPTH).
  - PC tag FIFO of DEPTH entries: records `imem_addr` at each grant; popped on every response, stored or dropped.
- **Issue**
  - `imem_req` = !`redirect` && (occupancy + `outstanding` < DEPTH).
  - On `imem_req`&&`imem_gnt`: `fetch_pc` += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) and `outstanding`++.
- **Response**
  - On `imem_rvalid`: `outstanding`--.
  - If `drop_cnt`>0: `drop_cnt`-- and discard the word.
  - Otherwise: write {`imem_rdata`, tag} at wr pointer; occupancy++.
- **Drain**
  - `instr_valid` = occupancy≠0.
  - `instr`/`instr_pc` come from the rd-pointer entry.
  - Pop on `instr_valid`&&`instr_ready`.
  - Push and pop in the same cycle leave occupancy unchanged.
- **Redirect**
  - In the pulse cycle: occupancy←0 and pointers←0. A simultaneous pop is ignored.
  - `fetch_pc`←{`redirect_pc`[31:2],2'b00}.
  - `drop_cnt`←`outstanding` − (`imem_rvalid` && `drop_cnt`==0 ? 1 : 0) + (`drop_cnt`>0 && `imem_rvalid` ? −1 : 0). This equals the number of in-flight responses remaining after this cycle.
  - A response arriving in the redirect cycle is discarded.
- **Overflow**
  - The credit rule (occupancy + `outstanding` ≤ DEPTH) guarantees a store never overflows.
  - A response with `outstanding`==0 is a protocol error: ignored, with a simulation assertion.

## Timing
- **Reset values:** `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0. All counters are 0.
- **First cycle after `rstn` deasserts:** `imem_req`=1, `imem_addr`=RESET_PC.
- **Back-to-back:** with `imem_gnt` held high and `instr_ready` high, one request issues per cycle.
- **Latency:** grant at cycle N and response at N+k give `instr_valid` at N+k+1. The buffer is registered, with no combinational path from `imem_rdata` to `instr`.
- **Redirect:** the next request goes to `redirect_pc` in the cycle after the pulse.
- **Reset mid-operation:** asynchronous clear of all state. In-flight memory responses arriving after reset release are the memory's responsibility and must be flushed by it.

## Configuration
- Macro: `FETCH_BYPASS_EN`.
- **Defined:** when occupancy==0 and a response is stored (not dropped) with `instr_ready`=1, `instr`/`instr_pc`/`instr_valid` are driven combinationally from `imem_rdata`/tag in the same cycle. The entry is consumed without being written. Latency is N+k.
- **Undefined:** fully registered behaviour as above, latency N+k+1.

## Test plan
- **Reset:** hold `rstn`=0, then release → `imem_req`=1, `imem_addr`=0 in the first cycle. With `imem_gnt`=1 and a 1-cycle response, `instr` shows 0x00A00893 with `instr_pc`=0x0, then PCs 0x4, 0x8, one per cycle.
- **Backpressure:** `instr_ready`=0, DEPTH=2 → exactly 2 grants (addresses 0x0, 0x4), then `imem_req`=0. Raising `instr_ready` drains 0x0 then 0x4, and `imem_req` reasserts at 0x8.
- **Redirect with 2 in flight:** pulse `redirect` with `redirect_pc`=0x0000_0103 → next `imem_addr`=0x100. The two stale responses are dropped; the first `instr_pc` seen is 0x100.
- **Redirect coincident with a response and a pop:** buffer is empty afterwards, the coincident word is discarded, and `drop_cnt` equals the remaining in-flight count.
- **Wrap-around:** RESET_PC=32'hFFFF_FFF8 → `instr_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **`FETCH_BYPASS_EN` defined:** a response at cycle T with the buffer empty and `instr_ready`=1 gives `instr_valid`=1 at T. Undefined: `instr_valid`=1 at T+1.
